// File: rtl/bus_uart_tx_pkg.sv
// bus_uart_tx_pkg: register map, status bit positions, FSM encoding and divisor defaults
package bus_uart_tx_pkg;
  localparam int BAUD_DIV_DEF = 434;
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV = 2'd2;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVF = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_e;
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction
endpackage

// File: rtl/bus_uart_tx_if.sv
// bus_uart_tx_if: CPU-side select/strobe bus with registered read data
interface bus_uart_tx_if;
  logic sel;
  logic w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master(output sel, w, addr, wdata, input rdata);
  modport slave(input sel, w, addr, wdata, output rdata);
endinterface

// File: rtl/bus_uart_tx_fifo.sv
// tx_fifo: byte FIFO with registered pointers and a combinational read port
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] cnt;
  assign dout = mem[rp];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and programmable divisor
module bus_uart_tx
  import bus_uart_tx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  bus_uart_tx_if.slave       bus,
  output logic               tx,
  output logic               irq_empty
);
  localparam logic [15:0] DIV_RST = 16'(BAUD_DIV);
  tx_state_e state, state_n;
  logic [15:0] div, bdiv, bdiv_n, cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n, dout;
  logic [31:0] status;
  logic full, empty, pop, push, ovf, wr, rd, wr_tx, busy, last, tx_n;
  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16]};
  assign wr = bus.sel & bus.w;
  assign rd = bus.sel & ~bus.w;
  assign wr_tx = wr && bus.addr[3:2] == REG_TXDATA;
  // a push into a full FIFO still lands when the shifter pops on the same edge
  assign push = wr_tx && (!full || pop);
  assign busy = state != IDLE;
  assign last = cnt == '0;
  assign irq_empty = empty && !busy;
  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din(bus.wdata[7:0]), .dout(dout), .full(full), .empty(empty)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt - 16'd1;
    idx_n = idx;
    shreg_n = shreg;
    bdiv_n = bdiv;
    pop = 1'b0;
    case (state)
      IDLE: cnt_n = cnt;
      START: if (last) begin
        state_n = DATA;
        cnt_n = bdiv - 16'd1;
        idx_n = 3'd0;
      end
      DATA: if (last) begin
        state_n = idx == 3'd7 ? STOP : DATA;
        cnt_n = bdiv - 16'd1;
        idx_n = idx + 3'd1;
      end
      STOP: if (last) state_n = IDLE;
    endcase
    // the divisor is latched per frame, so DIV writes mid-frame wait for the next byte
    if (!empty && (state == IDLE || (state == STOP && last))) begin
      pop = 1'b1;
      state_n = START;
      shreg_n = dout;
      bdiv_n = div;
      cnt_n = div - 16'd1;
    end
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[idx_n] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      bdiv <= DIV_RST;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shreg <= shreg_n;
      bdiv <= bdiv_n;
      tx <= tx_n;
    end
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY] = busy;
    status[ST_OVF] = ovf;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div <= DIV_RST;
      ovf <= 1'b0;
      bus.rdata <= '0;
    end else begin
      if (wr && bus.addr[3:2] == REG_DIV) div <= clamp_div(bus.wdata[15:0]);
      if (wr_tx && full && !pop) ovf <= 1'b1;
      else if (wr && bus.addr[3:2] == REG_STATUS && bus.wdata[3]) ovf <= 1'b0;
      if (rd) bus.rdata <= bus.addr[3:2] == REG_STATUS ? status :
                           bus.addr[3:2] == REG_DIV ? {16'd0, div} : '0;
    end
endmodule

// File: tb/tb_bus_uart_tx.sv
// tb_bus_uart_tx: scoreboard bench; expected frames and read data are queued at issue time
module tb_bus_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx, irq_empty;
  bus_uart_tx_if bus();
  bus_uart_tx dut (.clk(clk), .rst(rst), .bus(bus), .tx(tx), .irq_empty(irq_empty));
  always #5 clk = ~clk;
  typedef struct {logic [7:0] d; int div;} frame_t;
  frame_t exq[$];
  int starts[$];
  logic [31:0] rq[$];
  string rn[$];
  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic rd_pend = 1'b0;
  logic [31:0] rexp;
  string rname;
  always @(negedge clk) begin
    if (rd_pend) begin
      tests++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL read_unexpected: rdata=%h with no expected value", bus.rdata);
      end else begin
        rexp = rq.pop_front();
        rname = rn.pop_front();
        if (bus.rdata !== rexp) begin
          fails++;
          $display("FAIL %s: rdata=%h expected %h", rname, bus.rdata, rexp);
        end
      end
    end
    rd_pend = rst && bus.sel && !bus.w;
  end
  logic in_frame = 1'b0;
  int pos, bad, b;
  frame_t cur;
  logic [7:0] got;
  logic eb;
  always @(negedge clk) begin
    if (!rst) in_frame = 1'b0;
    else begin
      if (!in_frame && tx === 1'b0) begin
        if (exq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: start bit at cycle %0d", cyc);
          cur.d = 8'h00;
          cur.div = 1;
        end else cur = exq.pop_front();
        in_frame = 1'b1;
        pos = 0;
        bad = 0;
        got = 8'h00;
        starts.push_back(cyc);
      end
      if (in_frame) begin
        b = pos / cur.div;
        eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur.d[b-1];
        if (tx !== eb) bad++;
        if (b >= 1 && b <= 8 && pos % cur.div == cur.div / 2) got[b-1] = tx;
        pos++;
        if (pos == 10 * cur.div) begin
          tests++;
          if (bad != 0) begin
            fails++;
            $display("FAIL frame: got %h expected %h (div %0d, %0d bad samples)", got, cur.d, cur.div, bad);
          end
          in_frame = 1'b0;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.sel = 1'b1;
    bus.w = 1'b1;
    bus.addr = {28'd0, a};
    bus.wdata = d;
    tick();
    bus.sel = 1'b0;
    bus.w = 1'b0;
  endtask
  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
    rq.push_back(e);
    rn.push_back(n);
    bus.sel = 1'b1;
    bus.w = 1'b0;
    bus.addr = {28'd0, a};
    tick();
    bus.sel = 1'b0;
  endtask
  task automatic send(input logic [7:0] d, input int div);
    exq.push_back('{d, div});
    wr(4'h0, {24'd0, d});
  endtask
  task automatic wait_idle(input int maxc);
    int k = 0;
    while (k < maxc && !(exq.size() == 0 && !in_frame && irq_empty === 1'b1)) begin
      tick();
      k++;
    end
    check("idle_reached", {31'd0, k < maxc}, 32'd1);
  endtask
  task automatic wait_start();
    int k = 0;
    while (starts.size() == 0 && k < 200) begin
      tick();
      k++;
    end
    check("start_seen", {31'd0, k < 200}, 32'd1);
  endtask
  task automatic check_gaps(input int n, input int len);
    check("frame_count", starts.size(), n);
    for (int i = 1; i < starts.size(); i++) check("frame_gap", starts[i] - starts[i-1], len);
  endtask
  initial begin
    int c0, w0;
    bus.sel = 1'b0;
    bus.w = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (3) tick();
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_irq", {31'd0, irq_empty}, 32'd1);
    check("reset_rdata", bus.rdata, 32'd0);
    rst = 1'b1;
    tick();
    rd(4'h4, 32'h2, "status_rst");
    rd(4'h8, 32'd434, "div_rst");
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'hC, 32'h0, "reserved");
    rd(4'h8, 32'd434, "div_after_rsvd");
    // scenario 1: single 0x55 frame at DIV=4
    wr(4'h8, 32'd4);
    rd(4'h8, 32'd4, "div4");
    starts.delete();
    send(8'h55, 4);
    w0 = cyc;
    repeat (3) tick();
    rd(4'h4, 32'h6, "status_busy");
    wait_idle(200);
    check("s1_latency", starts[0], w0 + 1);
    check("s1_irq", {31'd0, irq_empty}, 32'd1);
    // scenario 2: fill, overflow, sticky, clear
    starts.delete();
    for (int i = 1; i <= 5; i++) send(8'(i), 4);
    wr(4'h0, 32'h06);
    rd(4'h4, 32'hD, "status_ovf");
    wr(4'h4, 32'h7);
    rd(4'h4, 32'hD, "ovf_sticky");
    wr(4'h4, 32'h8);
    rd(4'h4, 32'h5, "ovf_clr");
    wait_idle(400);
    check_gaps(5, 40);
    // scenario 3: push into a full FIFO on the STOP-to-START pop edge
    starts.delete();
    for (int i = 1; i <= 5; i++) send(8'hA0 + 8'(i), 4);
    wait_start();
    c0 = starts[0];
    while (cyc < c0 + 39) tick();
    send(8'hA6, 4);
    rd(4'h4, 32'h5, "s3_status");
    wait_idle(600);
    check_gaps(6, 40);
    // scenario 4: divisor clamp
    wr(4'h8, 32'd1);
    rd(4'h8, 32'd2, "div_clamp1");
    wr(4'h8, 32'd0);
    rd(4'h8, 32'd2, "div_clamp0");
    starts.delete();
    send(8'hC5, 2);
    send(8'h3A, 2);
    wait_idle(200);
    check_gaps(2, 20);
    // scenario 5: reset during DATA bit 3
    wr(4'h8, 32'd4);
    starts.delete();
    send(8'h00, 4);
    send(8'h11, 4);
    send(8'h22, 4);
    wait_start();
    c0 = starts[0];
    while (cyc < c0 + 17) tick();
    #2;
    check("s5_tx_low", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    #1;
    check("s5_tx_reset", {31'd0, tx}, 32'd1);
    check("s5_irq_reset", {31'd0, irq_empty}, 32'd1);
    exq.delete();
    starts.delete();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rd(4'h4, 32'h2, "s5_status");
    rd(4'h8, 32'd434, "s5_div");
    repeat (60) tick();
    check("s5_no_frames", starts.size(), 0);
    // scenario 6: DIV change mid-frame applies to the next frame
    wr(4'h8, 32'd4);
    starts.delete();
    send(8'h3C, 4);
    send(8'hC3, 8);
    repeat (10) tick();
    wr(4'h8, 32'd8);
    wait_idle(300);
    check_gaps(2, 40);
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
